// File: rtl/wb_sim_ctrl.sv
// Wishbone run controller: staggered channel resets, cycle counter, exit mailbox; single-cycle ack one edge after request,
// every other cycle under back-to-back strobes. Optional watchdog enabled by defining SIM_CTRL_WDOG_EN.
module wb_sim_ctrl #(
  parameter int          NCH         = 2,
  parameter int          RST_HOLD    = 16,
  parameter int          RST_STAGGER = 4,
  parameter logic [31:0] WDOG_INIT   = 32'd0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [3:0]     wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_we_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  output logic           wb_ack_o,
  output logic [NCH-1:0] rst_out,
  output logic           done,
  output logic [30:0]    exit_code,
  output logic           timeout
);

  typedef enum logic [1:0] {HOLD, STAGGER, RUN, FINISHED} state_t;

  localparam logic [31:0] FIRST_REL = 32'(RST_HOLD);
  localparam logic [31:0] LAST_REL  = 32'(RST_HOLD + (NCH - 1) * RST_STAGGER);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_EXIT  = 2'd1;
  localparam logic [1:0] A_CYCLE = 2'd2;
  localparam logic [1:0] A_WDOG  = 2'd3;

  state_t          state;
  logic [31:0]     cycle;
  logic [NCH-1:0]  ctrl;
  logic [NCH-1:0]  ctrl_nxt;
  logic [31:0]     wdog;
  logic [31:0]     rdata;
  logic            expire;

  wire        unused_ok = ^{wb_sel_i, wb_adr_i[1:0]};
  wire [1:0]  sel       = wb_adr_i[3:2];
  wire        req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  wire        wr        = req & wb_we_i & (state != FINISHED);
  wire        ctrl_wr   = wr & (sel == A_CTRL);
  wire        exit_wr   = wr & (sel == A_EXIT) & wb_dat_i[0];
  wire        wdog_wr   = wr & (sel == A_WDOG);

  always_comb begin
    ctrl_nxt = ctrl;
    if (ctrl_wr) ctrl_nxt = wb_dat_i[NCH-1:0];
  end

  always_comb begin
    rdata = '0;
    case (sel)
      A_CTRL:  rdata[NCH-1:0] = ctrl;
      A_EXIT:  rdata = {exit_code, done};
      A_CYCLE: rdata = cycle;
      default: rdata = wdog;
    endcase
  end

`ifdef SIM_CTRL_WDOG_EN
  // A reload or a winning EXIT write in the same cycle suppresses expiry.
  assign expire = (state == RUN) && (wdog == 32'd1) && !wdog_wr && !exit_wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog    <= WDOG_INIT;
      timeout <= 1'b0;
    end else begin
      if (wdog_wr)
        wdog <= wb_dat_i;
      else if (state == RUN && wdog != 32'd0 && !exit_wr)
        wdog <= wdog - 32'd1;
      if (expire) timeout <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign wdog    = 32'd0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      rst_out   <= '1;
      done      <= 1'b0;
      exit_code <= '0;
      cycle     <= '0;
      ctrl      <= '0;
      state     <= HOLD;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : 32'd0;
      if (state != FINISHED && cycle != 32'hFFFF_FFFF) cycle <= cycle + 32'd1;
      if (ctrl_wr) ctrl <= ctrl_nxt;

      if (exit_wr) begin
        done      <= 1'b1;
        exit_code <= wb_dat_i[31:1];
        state     <= FINISHED;
      end else if (expire) begin
        done      <= 1'b1;
        exit_code <= '1;
        state     <= FINISHED;
      end else begin
        case (state)
          HOLD, STAGGER: begin
            for (int i = 0; i < NCH; i++)
              rst_out[i] <= (cycle < 32'(RST_HOLD + i * RST_STAGGER));
            // Soft resets written during the release sequence take effect on RUN entry.
            if (cycle >= LAST_REL) begin
              state   <= RUN;
              rst_out <= ctrl_nxt;
            end else if (cycle >= FIRST_REL) begin
              state <= STAGGER;
            end
          end
          RUN:     rst_out <= ctrl_nxt;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_sim_ctrl.sv
// Directed bench for wb_sim_ctrl with NCH=2, RST_HOLD=10, RST_STAGGER=4.
module tb_wb_sim_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  adr   = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel   = 4'hF;
  logic        we    = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        ack;
  logic [1:0]  rst_out;
  logic        done;
  logic [30:0] exit_code;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int acks;
  logic [31:0] rd;

  always #5 clock = ~clock;

  wb_sim_ctrl #(.NCH(2), .RST_HOLD(10), .RST_STAGGER(4), .WDOG_INIT(32'd0)) dut (
    .clock(clock), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
    .rst_out(rst_out), .done(done), .exit_code(exit_code), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request sampled on the next rising edge R; returns #1 after edge R+1.
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    @(posedge clock); #1;
    chk("ack_high", 32'(ack), 32'd1);
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clock); #1;
    chk("ack_single", 32'(ack), 32'd0);
    chk("dat_idle", dat_o, 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rstout", 32'(rst_out), 32'd3);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exit", 32'(exit_code), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // Staggered release
    @(negedge clock); reset = 1'b0;
    for (int t = 0; t < 16; t++) begin
      @(posedge clock); #1;
      chk($sformatf("release_t%0d", t), 32'(rst_out),
          (t < 10) ? 32'd3 : (t < 14) ? 32'd2 : 32'd0);
    end
    repeat (4) @(posedge clock);
    bus(1'b0, 4'h8, 32'd0, rd);
    chk("cycle_t20", rd, 32'd20);

    // Soft resets in RUN
    bus(1'b1, 4'h0, 32'h2, rd);
    chk("ctrl_2", 32'(rst_out), 32'd2);
    bus(1'b1, 4'h0, 32'h0, rd);
    chk("ctrl_0", 32'(rst_out), 32'd0);
    bus(1'b1, 4'h0, 32'hFFFF_FFFD, rd);
    chk("ctrl_wide_rstout", 32'(rst_out), 32'd1);
    bus(1'b0, 4'h0, 32'd0, rd);
    chk("ctrl_read_masked", rd, 32'h1);
    bus(1'b1, 4'h0, 32'h0, rd);

    // Strobe held for 6 cycles
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      acks += int'(ack);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd3);

    // Reset mid-RUN, then CTRL=3 written at t=5
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("midreset_rstout", 32'(rst_out), 32'd3);
    @(negedge clock); reset = 1'b0;
    repeat (5) @(posedge clock);
    bus(1'b1, 4'h0, 32'h3, rd);
    bus(1'b0, 4'h8, 32'd0, rd);
    chk("cycle_restart_t7", rd, 32'd7);
    chk("hold_t8", 32'(rst_out), 32'd3);
    repeat (4) @(posedge clock); #1;
    chk("hold_t12", 32'(rst_out), 32'd2);
    repeat (2) @(posedge clock); #1;
    chk("ctrl_applied_t14", 32'(rst_out), 32'd3);
    repeat (3) @(posedge clock); #1;
    chk("ctrl_applied_t17", 32'(rst_out), 32'd3);

    // Exit mailbox: request edges 18, 20, 22, 24, 26, 28, 30
    bus(1'b1, 4'h4, 32'h6, rd);
    chk("exit_bit0_clear", 32'(done), 32'd0);
    bus(1'b1, 4'h4, 32'h1, rd);
    chk("exit_done", 32'(done), 32'd1);
    chk("exit_code0", 32'(exit_code), 32'd0);
    bus(1'b0, 4'h4, 32'd0, rd);
    chk("exit_read", rd, 32'h1);
    bus(1'b1, 4'h4, 32'h7, rd);
    chk("exit_sticky", 32'(exit_code), 32'd0);
    bus(1'b0, 4'h8, 32'd0, rd);
    chk("cycle_frozen", rd, 32'd21);
    bus(1'b1, 4'h0, 32'h0, rd);
    chk("done_rstout_frozen", 32'(rst_out), 32'd3);
    bus(1'b0, 4'h0, 32'd0, rd);
    chk("done_ctrl_unchanged", rd, 32'h3);
    bus(1'b0, 4'hC, 32'd0, rd);
`ifdef SIM_CTRL_WDOG_EN
    chk("wdog_read", rd, 32'd0);

    // Watchdog expiry: written at edge 16, expires at edge 21
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (16) @(posedge clock);
    bus(1'b1, 4'hC, 32'd5, rd);
    repeat (3) @(posedge clock); #1;
    chk("wdog_not_yet", 32'(done), 32'd0);
    @(posedge clock); #1;
    chk("wdog_timeout", 32'(timeout), 32'd1);
    chk("wdog_done", 32'(done), 32'd1);
    chk("wdog_code", 32'(exit_code), 32'h7FFF_FFFF);

    // EXIT on the expiry edge wins
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (16) @(posedge clock);
    bus(1'b1, 4'hC, 32'd5, rd);
    repeat (3) @(posedge clock);
    bus(1'b1, 4'h4, 32'h3, rd);
    chk("race_code", 32'(exit_code), 32'd1);
    chk("race_timeout", 32'(timeout), 32'd0);
    chk("race_done", 32'(done), 32'd1);
`else
    chk("wdog_read_zero", rd, 32'd0);
    chk("timeout_zero", 32'(timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
